// File: rtl/i2s_pkg.sv
// i2s_pkg: constants, the stereo sample type and the slot-to-bit mapping
// shared by the I2S transmitter and receiver.
package i2s_pkg;

    localparam int FRAME_CLKS   = 512;
    localparam int SLOT_BITS    = 32;
    localparam int CNT_W        = 9;
    localparam int SLOT_W       = $clog2(SLOT_BITS);
    localparam int SAMPLE_MAX_W = 31;

    // Samples are stored LSB-aligned in a fixed-width container so that one
    // type serves every legal WIDTH (8..31); unused upper bits stay zero.
    typedef struct packed {
        logic [SAMPLE_MAX_W-1:0] left;
        logic [SAMPLE_MAX_W-1:0] right;
    } stereo_sample_t;

    // Maps a slot number to {valid, bit index} for a WIDTH-bit sample.
    // Standard I2S puts the MSB one slot after the lrck edge; left-justified
    // puts it in the slot coincident with the edge. Invalid slots carry zero.
    function automatic logic [SLOT_W:0] slot_to_bit(input logic [SLOT_W-1:0] slot,
                                                    input int width,
                                                    input logic left_just);
        int s;
        int idx;
        logic hit;
        s = int'(slot);
        if (left_just) begin
            idx = width - 1 - s;
            hit = (s < width);
        end else begin
            idx = width - s;
            hit = (s >= 1) && (s <= width);
        end
        if (hit) begin
            return {1'b1, idx[SLOT_W-1:0]};
        end
        return '0;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: free-running 9-bit frame counter plus registered scki, bck and
// lrck derived from it. Every output comes straight from a flop.
module i2s_clkgen
    import i2s_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic             scki,
    output logic             bck,
    output logic             lrck
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             scki_q;
    logic             bck_q;
    logic             lrck_q;

    // Next count; the natural 9-bit wrap gives 511 -> 0.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter and clock registers; clocks track the counter bits they mirror.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            scki_q <= 1'b0;
            bck_q  <= 1'b0;
            lrck_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            scki_q <= cnt_d[0];
            bck_q  <= cnt_d[2];
            lrck_q <= cnt_d[8];
        end
    end

    assign cnt  = cnt_q;
    assign scki = scki_q;
    assign bck  = bck_q;
    assign lrck = lrck_q;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter. One-deep holding register fed by a
// valid/ready handshake, frame transfer into the active register at
// cnt==510, serial data updated on bck falling edges.
// Build option: define I2S_TX_LEFT_JUSTIFIED_EN for left-justified format.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             scki,
    output logic             bck,
    output logic             lrck,
    output logic             dout,
    output logic             underflow
);

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam logic LEFT_JUST = 1'b1;
`else
    localparam logic LEFT_JUST = 1'b0;
`endif

    localparam logic [CNT_W-1:0] XFER_CNT = CNT_W'(FRAME_CLKS - 2);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;
    logic              frame_xfer;
    stereo_sample_t    hold_q;
    logic              hold_full_q;
    logic              hold_full_d;
    stereo_sample_t    active_q;
    logic              underflow_q;
    logic              dout_q;
    logic              dout_d;
    logic [SLOT_W:0]   bit_sel;
    logic [SAMPLE_MAX_W-1:0] word;

    i2s_clkgen u_clkgen (
        .clk   (clk),
        .reset (reset),
        .cnt   (cnt),
        .scki  (scki),
        .bck   (bck),
        .lrck  (lrck)
    );

    assign in_ready   = !hold_full_q;
    assign accept     = in_valid && !hold_full_q;
    assign frame_xfer = (cnt == XFER_CNT);

    // Holding register occupancy: the frame transfer empties it, otherwise an accept fills it.
    always_comb begin
        hold_full_d = hold_full_q;
        if (frame_xfer && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (accept) begin
            hold_full_d = 1'b1;
        end
    end

    // Serial bit for the slot that starts after the coming bck falling edge.
    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        bit_sel  = slot_to_bit(cnt_next[7:3], WIDTH, LEFT_JUST);
        word     = cnt_next[8] ? active_q.right : active_q.left;
        dout_d   = bit_sel[SLOT_W] & word[bit_sel[SLOT_W-1:0]];
    end

    // Handshake, frame transfer, underflow flag and data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            active_q    <= '0;
            underflow_q <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            if (accept) begin
                hold_q.left  <= SAMPLE_MAX_W'(left);
                hold_q.right <= SAMPLE_MAX_W'(right);
            end
            if (frame_xfer) begin
                active_q <= hold_full_q ? hold_q : '0;
            end
            underflow_q <= frame_xfer && !hold_full_q;
            if (cnt[2:0] == 3'd7) begin
                dout_q <= dout_d;
            end
        end
    end

    assign dout      = dout_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx (WIDTH=24). Tracks the frame position
// itself, captures each frame's slot bits and compares against hand-computed
// patterns (bit 31-s of a pattern is the value carried by slot s).
module tb_i2s_tx;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic [31:0] i2sL;
        logic [31:0] i2sR;
        logic [31:0] ljL;
        logic [31:0] ljR;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] left = '0;
    logic [23:0] right = '0;
    logic        in_ready;
    logic        scki;
    logic        bck;
    logic        lrck;
    logic        dout;
    logic        underflow;

    i2s_tx #(.WIDTH(24)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .left      (left),
        .right     (right),
        .scki      (scki),
        .bck       (bck),
        .lrck      (lrck),
        .dout      (dout),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    vec_t        vecs[4];
    int          cnt;
    int          checkCount = 0;
    int          passCount = 0;
    logic [31:0] curL, curR, lastL, lastR;
    logic [511:0] curDout, lastDout;
    int          curUf, lastUf, curUfAt, lastUfAt;
    logic        ready510, ready511;
    logic        prevScki, prevBck, prevLrck;
    int          sckiToggles, bckToggles, lrckToggles, badLrEdges, notReady;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic clearFrame();
        curL = '0;
        curR = '0;
        curDout = '0;
        curUf = 0;
        curUfAt = -1;
    endtask

    // One clock: advance the model position, sample 1 time unit later, collect.
    task automatic tick();
        logic [8:0] c;
        logic [4:0] slotIdx;
        @(posedge clk);
        cnt = (cnt + 1) % 512;
        #1;
        c = cnt[8:0];
        slotIdx = c[7:3];
        curDout[c] = dout;
        if (underflow) begin
            curUf++;
            curUfAt = cnt;
        end
        if (c[2:0] == 3'd4) begin
            if (!c[8]) curL[5'd31 - slotIdx] = dout;
            else       curR[5'd31 - slotIdx] = dout;
        end
        if (scki != prevScki) sckiToggles++;
        if (bck != prevBck) bckToggles++;
        if (lrck != prevLrck) begin
            lrckToggles++;
            if (!(prevBck && !bck)) badLrEdges++;
        end
        if (!in_ready) notReady++;
        prevScki = scki;
        prevBck = bck;
        prevLrck = lrck;
        if (cnt == 510) ready510 = in_ready;
        if (cnt == 511) begin
            ready511 = in_ready;
            lastL = curL;
            lastR = curR;
            lastDout = curDout;
            lastUf = curUf;
            lastUfAt = curUfAt;
            clearFrame();
        end
    endtask

    task automatic runTo(input int target);
        int n;
        n = 0;
        while (cnt != target && n < 1100) begin
            tick();
            n++;
        end
        if (cnt != target) checkOutput("runTo timeout", 32'(cnt), 32'(target));
    endtask

    // Present a pair and hold it until the handshake completes; returns cnt after the accepting edge.
    task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, output int acceptCnt);
        logic readyBefore;
        int n;
        left = l;
        right = r;
        in_valid = 1'b1;
        acceptCnt = -1;
        n = 0;
        while (acceptCnt < 0 && n < 1100) begin
            readyBefore = in_ready;
            tick();
            if (readyBefore) acceptCnt = cnt;
            n++;
        end
        in_valid = 1'b0;
        if (acceptCnt < 0) checkOutput("handshake timeout", 32'(n), 32'(0));
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        clearFrame();
        prevScki = 1'b0;
        prevBck = 1'b0;
        prevLrck = 1'b0;
    endtask

    function automatic logic [31:0] expL(input int i);
        return LJ ? vecs[i].ljL : vecs[i].i2sL;
    endfunction

    function automatic logic [31:0] expR(input int i);
        return LJ ? vecs[i].ljR : vecs[i].i2sR;
    endfunction

    initial begin
        int acc;
        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 32'h52D2D280, 32'h2D2D2D00, 32'hA5A5A500, 32'h5A5A5A00};
        vecs[1] = '{24'h800001, 24'h7FFFFF, 32'h40000080, 32'h3FFFFF80, 32'h80000100, 32'h7FFFFF00};
        vecs[2] = '{24'hFFFFFF, 24'h000001, 32'h7FFFFF80, 32'h00000080, 32'hFFFFFF00, 32'h00000100};
        vecs[3] = '{24'h123456, 24'hABCDEF, 32'h091A2B00, 32'h55E6F780, 32'h12345600, 32'hABCDEF00};
        cnt = 0;
        clearFrame();
        lastL = '0; lastR = '0; lastDout = '0; lastUf = 0; lastUfAt = -1;
        ready510 = 1'b0; ready511 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", 32'({scki, bck, lrck, dout, underflow, in_ready}), 32'h1);
        releaseReset();

        // Clock ratios over 2048 clocks with no samples supplied
        sckiToggles = 0; bckToggles = 0; lrckToggles = 0; badLrEdges = 0; notReady = 0;
        repeat (2048) tick();
        checkOutput("scki toggles", 32'(sckiToggles), 32'd2048);
        checkOutput("bck toggles", 32'(bckToggles), 32'd512);
        checkOutput("lrck toggles", 32'(lrckToggles), 32'd8);
        checkOutput("lrck off bck fall", 32'(badLrEdges), 32'd0);
        checkOutput("in_ready low cycles", 32'(notReady), 32'd0);
        checkOutput("idle frame left", lastL, 32'h0);
        checkOutput("idle frame right", lastR, 32'h0);
        checkOutput("idle underflow count", 32'(lastUf), 32'd1);
        checkOutput("idle underflow cnt", 32'(lastUfAt), 32'd511);

        // Table-driven transfers: push at cnt 20, play on the next frame
        for (int i = 0; i < 4; i++) begin
            runTo(20);
            applyStimulus(vecs[i].left, vecs[i].right, acc);
            checkOutput($sformatf("v%0d accept cnt", i), 32'(acc), 32'd21);
            checkOutput($sformatf("v%0d ready after push", i), 32'(in_ready), 32'd0);
            runTo(511);
            checkOutput($sformatf("v%0d push frame underflow", i), 32'(lastUf), 32'd0);
            checkOutput($sformatf("v%0d ready at 510", i), 32'(ready510), 32'd0);
            checkOutput($sformatf("v%0d ready at 511", i), 32'(ready511), 32'd1);
            tick();
            runTo(511);
            checkOutput($sformatf("v%0d left", i), lastL, expL(i));
            checkOutput($sformatf("v%0d right", i), lastR, expR(i));
            checkOutput($sformatf("v%0d play frame underflow cnt", i), 32'(lastUfAt), 32'd511);
            if (i == 0) begin
                checkOutput("v0 dout@0", 32'(lastDout[0]), LJ ? 32'd1 : 32'd0);
                checkOutput("v0 dout@7", 32'(lastDout[7]), LJ ? 32'd1 : 32'd0);
                checkOutput("v0 dout@8", 32'(lastDout[8]), LJ ? 32'd0 : 32'd1);
                checkOutput("v0 dout@15", 32'(lastDout[15]), LJ ? 32'd0 : 32'd1);
            end
            tick();
        end

        // Backpressure: P2 waits for the transfer, then both play back to back
        runTo(30);
        applyStimulus(vecs[0].left, vecs[0].right, acc);
        checkOutput("bp ready low", 32'(in_ready), 32'd0);
        applyStimulus(vecs[1].left, vecs[1].right, acc);
        checkOutput("bp p2 accept cnt", 32'(acc), 32'd0);
        checkOutput("bp push frame underflow", 32'(lastUf), 32'd0);
        runTo(511);
        checkOutput("bp p1 left", lastL, expL(0));
        checkOutput("bp p1 right", lastR, expR(0));
        checkOutput("bp p1 frame underflow", 32'(lastUf), 32'd0);
        tick();
        runTo(511);
        checkOutput("bp p2 left", lastL, expL(1));
        checkOutput("bp p2 right", lastR, expR(1));
        checkOutput("bp p2 frame underflow", 32'(lastUf), 32'd1);

        // Accept exactly on the cnt==510 edge with the holding register empty
        tick();
        runTo(510);
        left = vecs[2].left;
        right = vecs[2].right;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("sim underflow pulse", 32'(underflow), 32'd1);
        checkOutput("sim ready after accept", 32'(in_ready), 32'd0);
        tick();
        checkOutput("sim underflow one cycle", 32'(underflow), 32'd0);
        runTo(511);
        checkOutput("sim zero frame left", lastL, 32'h0);
        checkOutput("sim zero frame right", lastR, 32'h0);
        checkOutput("sim zero frame underflow", 32'(lastUf), 32'd0);
        tick();
        runTo(511);
        checkOutput("sim pair left", lastL, expL(2));
        checkOutput("sim pair right", lastR, expR(2));

        // Reset mid-frame with a pair held
        tick();
        runTo(100);
        applyStimulus(vecs[3].left, vecs[3].right, acc);
        runTo(300);
        reset = 1'b0;
        #1;
        checkOutput("midreset outputs", 32'({scki, bck, lrck, dout, underflow, in_ready}), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midreset held", 32'({scki, bck, lrck, dout, underflow, in_ready}), 32'h1);
        releaseReset();
        runTo(511);
        checkOutput("post-reset left", lastL, 32'h0);
        checkOutput("post-reset right", lastR, 32'h0);
        checkOutput("post-reset underflow cnt", 32'(lastUfAt), 32'd511);
        tick();
        runTo(50);
        applyStimulus(vecs[3].left, vecs[3].right, acc);
        runTo(511);
        checkOutput("post-reset push frame left", lastL, 32'h0);
        tick();
        runTo(511);
        checkOutput("post-reset v3 left", lastL, expL(3));
        checkOutput("post-reset v3 right", lastR, expR(3));
        checkOutput("post-reset dout@4", 32'(lastDout[4]), LJ ? 32'd0 : 32'd0);
        checkOutput("post-reset dout@12", 32'(lastDout[12]), LJ ? 32'd0 : 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter feeding the stereo DAC; the transmit-side counterpart of the existing i2s receiver.
- Accepts stereo sample pairs over a valid/ready handshake into a one-deep holding register.
- Generates scki, bck and lrck from clk and shifts samples out MSB-first on dout.
- Fs = clk/512 (256·Fs scki, 64·Fs bck). On underflow it sends zeros and flags it.

Parameters:
- WIDTH, 24, bits per channel sample; legal range 8..31.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  sample pair valid
- in_ready  output  1  holding register empty, so a pair can be accepted
- left  input  WIDTH  left sample, two's complement
- right  input  WIDTH  right sample, two's complement
- scki  output  1  DAC system clock = clk/2
- bck  output  1  bit clock = clk/8
- lrck  output  1  word select: 0 = left, 1 = right; period 512 clk
- dout  output  1  serial data
- underflow  output  1  one-clk pulse when a frame starts with no sample held

Behaviour:
- Reset (reset=0, async): cnt=0, scki=bck=lrck=dout=0, hold_full=0, hold and active registers =0, underflow=0, in_ready=1.
- Timing counter: 9-bit free-running counter cnt, +1 per clk, wraps 511→0.
  - scki=cnt[0], bck=cnt[2], lrck=cnt[8]; all driven from registers, glitch-free.
  - Slot index = cnt[7:3], 32 slots per channel.
  - lrck and dout change only on bck falling edges (cnt[2:0] 7→0). The DAC samples dout on bck rising edges (cnt[2:0]==4).
- Handshake:
  - Accept on posedge when in_valid && in_ready: hold <= {left,right}, hold_full <= 1.
  - in_ready = !hold_full.
  - left/right need only be stable while in_valid is high.
- Frame transfer, on posedge with cnt==510:
  - If hold_full: active <= hold, hold_full <= 0.
  - Else: active <= 0, underflow=1 for exactly the next cycle.
  - The transfer uses pre-edge hold_full. If an accept occurs in the same cycle as an empty transfer, the frame outputs zeros, underflow pulses, and the new pair stays in hold for the following frame.
- dout register: updated on posedge with cnt[2:0]==7, using the slot/channel of cnt+1 (wrapping).
  - I2S format: slot s in 1..WIDTH carries channel bit WIDTH-s (MSB in slot 1, one bck after the lrck edge). Slot 0 and slots >WIDTH carry 0.
  - Channel is left when (cnt+1)[8]==0.
- Latency: a pair accepted before cnt==510 appears on the frame starting at the next cnt==0.
  - Left MSB is on dout from cnt==8 through cnt==15.
- Reset mid-frame: all state clears immediately and clocks stop low. After release, the first frame transmits zeros and pulses underflow at cnt==510 unless a pair was accepted before that point.
- Sample bits are transmitted verbatim; no sign extension or truncation.

Optional Feature:
- Macro I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. Slot s in 0..WIDTH-1 carries bit WIDTH-1-s (MSB in slot 0, coincident with the lrck edge); other slots 0. The transfer still occurs at cnt==510, so left MSB drives dout from cnt==0.
- Undefined: standard I2S one-bck delay as above. Ports and clocks are identical in both builds.

Decomposition:
- Package i2s_pkg holds:
  - constants FRAME_CLKS=512, SLOT_BITS=32, CNT_W=9
  - typedef stereo_sample_t (struct of left/right, WIDTH bits)
  - a shared slot-to-bit-index function, also usable by the receiver.
- Sub-module i2s_clkgen: owns cnt and the registered scki/bck/lrck, and exports cnt. i2s_tx instantiates it plus the hold/active/shift datapath.

Test Plan:
- Clock ratios: release reset, run 2048 clk → scki period 2, bck period 8, lrck period 512. lrck edges only where bck falls. in_ready=1.
- Basic transfer (I2S build): push left=24'hA5A5A5, right=24'h5A5A5A at cycle 20, then sample dout at bck rising edges of the next frame.
  - Left slots 1..24 = A5A5A5 MSB-first; slots 0 and 25..31 = 0.
  - Right slots 1..24 = 5A5A5A.
  - in_ready returns to 1 the cycle after cnt==510.
- Underflow: no push after reset → underflow high exactly one cycle after cnt==510; the whole next frame is dout=0. Pushing 24'h800001/24'h7FFFFF mid-frame then plays that pair on the following frame.
- Backpressure: push pair P1, then hold in_valid with P2 → in_ready=0, P2 held off until the transfer, accepted the next cycle. P1 then P2 play on consecutive frames with no underflow.
- Simultaneous: hold empty, accept pair exactly at cnt==510 → underflow pulses, that frame is zeros, the pair plays the next frame.
- Reset mid-frame at cnt==300 (and left-justified build repeat): outputs zero immediately. With left-justified enabled, the left MSB is valid at the first bck rise after cnt 0 (cnt==4).
